// File: rtl/trap_unit.sv
// ============================================================================
// Module   : trap_unit
// Purpose  : Machine-mode trap/MRET sequencer with CSR file (mstatus, mie,
//            mtvec, mepc, mcause, mip) and a registered one-cycle redirect.
//            Timer interrupts exist only when TRAP_TIMER_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        invalid_instruction,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;

  typedef enum logic {ST_IDLE = 1'b0, ST_REDIRECT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic        mie_mtie_q;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        w_can_event;
  logic        w_ext_pend;
  logic        w_tmr_pend;
  logic        w_trap;
  logic        w_mret;
  logic        w_event;
  logic [31:0] w_cause;
  logic        unused_bits;

`ifdef TRAP_TIMER_IRQ_EN
  logic mie_mtie_d;
  assign w_tmr_pend  = mstatus_mie_q & mie_mtie_q & timer_irq;
  assign unused_bits = ^cm_pc[1:0];
`else
  assign mie_mtie_q  = 1'b0;
  assign w_tmr_pend  = 1'b0;
  assign unused_bits = ^{cm_pc[1:0], timer_irq};
`endif

  // Only a live commit in IDLE can raise an event; the REDIRECT-cycle slot is flushed.
  assign w_can_event = cm_valid & (state_q == ST_IDLE);
  assign w_ext_pend  = mstatus_mie_q & mie_meie_q & ext_irq;
  assign w_trap      = w_can_event & (invalid_instruction | is_ecall | w_ext_pend | w_tmr_pend);
  assign w_mret      = w_can_event & is_mret & ~w_trap;
  assign w_event     = w_trap | w_mret;

  assign w_cause = invalid_instruction ? CAUSE_ILLEGAL :
                   is_ecall            ? CAUSE_ECALL   :
                   w_ext_pend          ? CAUSE_EXT     : CAUSE_TIMER;

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      ADDR_MIE:     csr_rdata = {20'h0, mie_meie_q, 3'b000, mie_mtie_q, 7'h00};
      ADDR_MTVEC:   csr_rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:    csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:  csr_rdata = mcause_q;
`ifdef TRAP_TIMER_IRQ_EN
      ADDR_MIP:     csr_rdata = {20'h0, ext_irq, 3'b000, timer_irq, 7'h00};
`else
      ADDR_MIP:     csr_rdata = {20'h0, ext_irq, 11'h000};
`endif
      default:      csr_rdata = 32'h0;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
`ifdef TRAP_TIMER_IRQ_EN
    mie_mtie_d     = mie_mtie_q;
`endif
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    state_d        = ST_IDLE;
    redirect_d     = 1'b0;
    redirect_pc_d  = 32'h0;

    // Software writes to mstatus/mepc/mcause lose to a simultaneous trap or MRET.
    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: if (!w_event) begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        ADDR_MIE: begin
          mie_meie_d = csr_wdata[11];
`ifdef TRAP_TIMER_IRQ_EN
          mie_mtie_d = csr_wdata[7];
`endif
        end
        ADDR_MTVEC:  mtvec_d = csr_wdata[31:2];
        ADDR_MEPC:   if (!w_event) mepc_d = csr_wdata[31:2];
        ADDR_MCAUSE: if (!w_event) mcause_d = csr_wdata;
        default: ;
      endcase
    end

    if (w_trap) begin
      mepc_d         = cm_pc[31:2];
      mcause_d       = w_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      state_d        = ST_REDIRECT;
      redirect_d     = 1'b1;
      redirect_pc_d  = {mtvec_q, 2'b00};
    end else if (w_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      state_d        = ST_REDIRECT;
      redirect_d     = 1'b1;
      redirect_pc_d  = {mepc_q, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
`ifdef TRAP_TIMER_IRQ_EN
      mie_mtie_q     <= 1'b0;
`endif
      mtvec_q        <= 30'h0;
      mepc_q         <= 30'h0;
      mcause_q       <= 32'h0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
`ifdef TRAP_TIMER_IRQ_EN
      mie_mtie_q     <= mie_mtie_d;
`endif
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
// Module   : tb_trap_unit
// Purpose  : Directed scoreboard bench for trap_unit; expected redirect
//            targets are queued at issue and checked by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cm_valid, invalid_instruction, is_ecall, is_mret;
  logic        ext_irq, timer_irq, csr_we;
  logic [31:0] cm_pc, csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  trap_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cm_valid            (cm_valid),
    .cm_pc               (cm_pc),
    .invalid_instruction (invalid_instruction),
    .is_ecall            (is_ecall),
    .is_mret             (is_mret),
    .ext_irq             (ext_irq),
    .timer_irq           (timer_irq),
    .csr_we              (csr_we),
    .csr_addr            (csr_addr),
    .csr_wdata           (csr_wdata),
    .csr_rdata           (csr_rdata),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic cwr(input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic ill, input logic ec, input logic mr);
    @(posedge clk); #1;
    cm_valid = 1'b1; cm_pc = pc; invalid_instruction = ill; is_ecall = ec; is_mret = mr;
    @(posedge clk); #1;
    cm_valid = 1'b0; invalid_instruction = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    csr_we = 1'b0;
  endtask

  // Monitor: every observed redirect must match the oldest queued target.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && redirect) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_redirect: got redirect_pc %08h expected no redirect", redirect_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("redirect_pc", redirect_pc, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cm_valid = 1'b0; cm_pc = 32'h0; invalid_instruction = 1'b0;
    is_ecall = 1'b0; is_mret = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    #1;
    chk("rst_redirect", {31'h0, redirect}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Illegal instruction trap, mtvec low bits forced to zero
    cwr(12'h305, 32'h0000_0103);
    rd("mtvec_align", 12'h305, 32'h0000_0100);
    exp_q.push_back(32'h0000_0100);
    commit(32'h40, 1'b1, 1'b0, 1'b0);
    rd("ill_mepc", 12'h341, 32'h40);
    rd("ill_mcause", 12'h342, 32'h2);
    rd("ill_mstatus", 12'h300, 32'h0);
    @(posedge clk); #1;
    chk("idle_redirect_pc", redirect_pc, 32'h0);

    // MRET with MIE=1, MPIE=0 restores MIE=0 and sets MPIE
    cwr(12'h300, 32'h8);
    exp_q.push_back(32'h40);
    commit(32'h104, 1'b0, 1'b0, 1'b1);
    rd("mret_mstatus", 12'h300, 32'h80);

    // Exception beats a pending external interrupt
    cwr(12'h304, 32'h800);
    cwr(12'h300, 32'h8);
    ext_irq = 1'b1;
    rd("mip_ext", 12'h344, 32'h800);
    exp_q.push_back(32'h100);
    commit(32'h80, 1'b1, 1'b0, 1'b0);
    rd("exc_wins_mcause", 12'h342, 32'h2);
    rd("exc_wins_mstatus", 12'h300, 32'h80);
    commit(32'h84, 1'b0, 1'b0, 1'b0);
    rd("masked_mepc", 12'h341, 32'h80);
    ext_irq = 1'b0;

    // Both interrupts pending: external wins; event in REDIRECT cycle ignored
    cwr(12'h304, 32'h880);
`ifdef TRAP_TIMER_IRQ_EN
    rd("mie_both", 12'h304, 32'h880);
`else
    rd("mie_both", 12'h304, 32'h800);
`endif
    cwr(12'h300, 32'h8);
    exp_q.push_back(32'h100);
    @(posedge clk); #1;
    ext_irq = 1'b1; timer_irq = 1'b1; cm_valid = 1'b1; cm_pc = 32'h20;
    @(posedge clk); #1;
    is_ecall = 1'b1; cm_pc = 32'h24;
    @(posedge clk); #1;
    cm_valid = 1'b0; is_ecall = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc", 12'h341, 32'h20);

    // CSR write to mepc loses to coincident ECALL
    exp_q.push_back(32'h100);
    @(posedge clk); #1;
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h200;
    cm_valid = 1'b1; cm_pc = 32'h60; is_ecall = 1'b1;
    @(posedge clk); #1;
    csr_we = 1'b0; cm_valid = 1'b0; is_ecall = 1'b0;
    rd("ecall_mepc", 12'h341, 32'h60);
    rd("ecall_mcause", 12'h342, 32'hB);
    rd("ecall_mstatus", 12'h300, 32'h0);

    exp_q.push_back(32'h60);
    commit(32'h64, 1'b0, 1'b0, 1'b1);
    rd("mret2_mstatus", 12'h300, 32'h80);

    // Unmapped and mip writes ignored; direct CSR writes
    cwr(12'h7C0, 32'hFFFF_FFFF);
    rd("unmapped", 12'h7C0, 32'h0);
    cwr(12'h344, 32'hFFFF_FFFF);
    rd("mip_ro", 12'h344, 32'h0);
    cwr(12'h342, 32'h1234_5678);
    rd("mcause_wr", 12'h342, 32'h1234_5678);
    cwr(12'h341, 32'h207);
    rd("mepc_align", 12'h341, 32'h204);

    // Timer interrupt gated by configuration
    cwr(12'h300, 32'h8);
    timer_irq = 1'b1;
`ifdef TRAP_TIMER_IRQ_EN
    exp_q.push_back(32'h100);
    commit(32'h70, 1'b0, 1'b0, 1'b0);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mip", 12'h344, 32'h80);
`else
    commit(32'h70, 1'b0, 1'b0, 1'b0);
    rd("tmr_off_mstatus", 12'h300, 32'h8);
    rd("tmr_off_mip", 12'h344, 32'h0);
`endif
    timer_irq = 1'b0;

    // Asynchronous reset while redirect is high
    @(posedge clk); #1;
    cm_valid = 1'b1; cm_pc = 32'h90; is_ecall = 1'b1;
    @(posedge clk); #1;
    cm_valid = 1'b0; is_ecall = 1'b0;
    chk("pre_rst_redirect", {31'h0, redirect}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_redirect", {31'h0, redirect}, 32'h0);
    chk("async_rst_pc", redirect_pc, 32'h0);
    rd("async_rst_mtvec", 12'h305, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
